// File: rtl/apb_regif_slave.sv
// APB-to-register-interface bridge: one outstanding access, IDLE/WAIT/RESP sequencing.
// Optional WAIT-cycle timeout with error response is compiled in by APB_REGIF_TIMEOUT_EN.
module apb_regif_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ack,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state;
  logic       is_write;
  logic       setup;
  logic       wr_done;
  logic       rd_done;
  logic       ack_done;
  logic       expire;

  assign setup    = psel & ~penable;
  // Only the ack matching the captured direction counts, and only while waiting.
  assign wr_done  = (state == ST_WAIT) & is_write & reg_wr_ack;
  assign rd_done  = (state == ST_WAIT) & ~is_write & reg_rd_ack;
  assign ack_done = wr_done | rd_done;

`ifdef APB_REGIF_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       pslverr_r;

  // Expiry fires on the last allowed WAIT cycle; an ack in that cycle wins.
  assign expire  = (state == ST_WAIT) & ~ack_done & (wait_cnt == TO_LAST);
  assign pslverr = pslverr_r;

  // WAIT-cycle counter and error flag for the timed-out response.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wait_cnt  <= 8'd0;
      pslverr_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pslverr_r <= 1'b0;
          if (setup) begin
            wait_cnt <= 8'd0;
          end
        end
        ST_WAIT: begin
          if (ack_done) begin
            pslverr_r <= 1'b0;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
            pslverr_r <= expire;
          end
        end
        ST_RESP: begin
          pslverr_r <= 1'b0;
        end
        default: begin
          wait_cnt  <= 8'd0;
          pslverr_r <= 1'b0;
        end
      endcase
    end
  end
`else
  assign expire  = 1'b0;
  assign pslverr = 1'b0;
`endif

  // Transfer sequencing, register-side request outputs and APB response.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      pready      <= 1'b0;
      prdata      <= '0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
      reg_wr_en   <= 1'b0;
      reg_rd_addr <= '0;
      reg_rd_en   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pready <= 1'b0;
          if (setup) begin
            state       <= ST_WAIT;
            is_write    <= pwrite;
            reg_wr_addr <= paddr;
            reg_wr_data <= pwdata;
            reg_wr_strb <= pstrb;
            reg_rd_addr <= paddr;
            reg_wr_en   <= pwrite;
            reg_rd_en   <= ~pwrite;
          end
        end
        ST_WAIT: begin
          if (ack_done) begin
            state     <= ST_RESP;
            pready    <= 1'b1;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            prdata    <= rd_done ? reg_rd_data : '0;
          end else if (expire) begin
            state     <= ST_RESP;
            pready    <= 1'b1;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            prdata    <= '0;
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          pready <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          pready    <= 1'b0;
          reg_wr_en <= 1'b0;
          reg_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regif_slave.sv
// Directed self-checking bench for apb_regif_slave (TIMEOUT_CYCLES=4).
module tb_apb_regif_slave;

  logic        clk_i = 1'b0;
  logic        srst_i = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic [3:0]  pstrb = 4'd0;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;
  logic [31:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en;
  logic        reg_wr_ack = 1'b0;
  logic [31:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data = 32'd0;
  logic        reg_rd_ack = 1'b0;

  int total = 0;
  int passed = 0;

  apb_regif_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_ack(reg_rd_ack)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = 4'hF;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; reg_wr_ack = 1'b0; reg_rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    tick(); tick();
    srst_i = 1'b0;
    total++; if (pready !== 1'b0) $display("FAIL rst_pready got %h exp 0", pready); else passed++;
    total++; if (pslverr !== 1'b0) $display("FAIL rst_pslverr got %h exp 0", pslverr); else passed++;
    total++; if ({reg_wr_en, reg_rd_en} !== 2'b00) $display("FAIL rst_en got %b exp 00", {reg_wr_en, reg_rd_en}); else passed++;
    total++; if (prdata !== 32'd0) $display("FAIL rst_prdata got %h exp 0", prdata); else passed++;
    total++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb, reg_rd_addr} !== 100'd0) $display("FAIL rst_regside got nonzero exp 0"); else passed++;
  endtask

  task automatic test_write();
    bus_setup(1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    total++; if ({reg_wr_en, reg_rd_en} !== 2'b10) $display("FAIL wr_en got %b exp 10", {reg_wr_en, reg_rd_en}); else passed++;
    total++; if (reg_wr_addr !== 32'h10) $display("FAIL wr_addr got %h exp 10", reg_wr_addr); else passed++;
    total++; if (reg_wr_data !== 32'hDEADBEEF) $display("FAIL wr_data got %h exp deadbeef", reg_wr_data); else passed++;
    total++; if (reg_wr_strb !== 4'hF) $display("FAIL wr_strb got %h exp f", reg_wr_strb); else passed++;
    total++; if (pready !== 1'b0) $display("FAIL wr_pready_wait got %h exp 0", pready); else passed++;
    penable = 1'b1; reg_wr_ack = 1'b1;
    tick();
    total++; if (reg_wr_en !== 1'b0) $display("FAIL wr_en_drop got %h exp 0", reg_wr_en); else passed++;
    total++; if (pready !== 1'b1) $display("FAIL wr_pready got %h exp 1", pready); else passed++;
    total++; if (pslverr !== 1'b0) $display("FAIL wr_pslverr got %h exp 0", pslverr); else passed++;
    total++; if (prdata !== 32'd0) $display("FAIL wr_prdata got %h exp 0", prdata); else passed++;
    bus_idle();
    tick();
    total++; if (pready !== 1'b0) $display("FAIL wr_pready_once got %h exp 0", pready); else passed++;
  endtask

  task automatic test_read();
    bus_setup(1'b0, 32'h24, 32'h0);
    tick();
    total++; if ({reg_wr_en, reg_rd_en} !== 2'b01) $display("FAIL rd_en got %b exp 01", {reg_wr_en, reg_rd_en}); else passed++;
    total++; if (reg_rd_addr !== 32'h24) $display("FAIL rd_addr got %h exp 24", reg_rd_addr); else passed++;
    penable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if ({reg_rd_en, pready} !== 2'b10) $display("FAIL rd_wait%0d got %b exp 10", i, {reg_rd_en, pready}); else passed++;
    end
    tick();
    reg_rd_ack = 1'b1; reg_rd_data = 32'h12345678;
    tick();
    total++; if (pready !== 1'b1) $display("FAIL rd_pready got %h exp 1", pready); else passed++;
    total++; if (prdata !== 32'h12345678) $display("FAIL rd_prdata got %h exp 12345678", prdata); else passed++;
    total++; if ({reg_rd_en, pslverr} !== 2'b00) $display("FAIL rd_done got %b exp 00", {reg_rd_en, pslverr}); else passed++;
    bus_idle();
    tick();
    total++; if (pready !== 1'b0) $display("FAIL rd_pready_once got %h exp 0", pready); else passed++;
    total++; if (prdata !== 32'h12345678) $display("FAIL rd_prdata_hold got %h exp 12345678", prdata); else passed++;
  endtask

  task automatic test_reset_in_wait();
    bus_setup(1'b1, 32'h50, 32'hA5A5A5A5);
    tick();
    total++; if (reg_wr_en !== 1'b1) $display("FAIL rw_en got %h exp 1", reg_wr_en); else passed++;
    penable = 1'b1; srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    total++; if ({reg_wr_en, reg_rd_en, pready, pslverr} !== 4'b0000) $display("FAIL rw_ctl got %b exp 0000", {reg_wr_en, reg_rd_en, pready, pslverr}); else passed++;
    total++; if ({reg_wr_addr, reg_wr_data, reg_wr_strb, prdata} !== 100'd0) $display("FAIL rw_data got nonzero exp 0"); else passed++;
    psel = 1'b0; penable = 1'b0; reg_wr_ack = 1'b1;
    tick();
    reg_wr_ack = 1'b0;
    total++; if ({reg_wr_en, pready} !== 2'b00) $display("FAIL rw_late_ack got %b exp 00", {reg_wr_en, pready}); else passed++;
    bus_setup(1'b0, 32'h0, 32'h0);
    tick();
    total++; if ({reg_rd_en, reg_rd_addr} !== {1'b1, 32'h0}) $display("FAIL rw_rd_en got %b/%h exp 1/0", reg_rd_en, reg_rd_addr); else passed++;
    penable = 1'b1; reg_rd_ack = 1'b1; reg_rd_data = 32'h0BADF00D;
    tick();
    total++; if ({pready, prdata} !== {1'b1, 32'h0BADF00D}) $display("FAIL rw_rd got %b/%h exp 1/0badf00d", pready, prdata); else passed++;
    bus_idle();
    tick();
  endtask

  task automatic test_timeout();
    bus_setup(1'b0, 32'h30, 32'h0);
    tick();
    penable = 1'b1;
`ifdef APB_REGIF_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      total++; if ({reg_rd_en, pready} !== 2'b10) $display("FAIL to_wait%0d got %b exp 10", i, {reg_rd_en, pready}); else passed++;
      tick();
    end
    total++; if ({reg_rd_en, pready, pslverr} !== 3'b011) $display("FAIL to_resp got %b exp 011", {reg_rd_en, pready, pslverr}); else passed++;
    total++; if (prdata !== 32'd0) $display("FAIL to_prdata got %h exp 0", prdata); else passed++;
    bus_idle();
    tick();
    total++; if ({pready, pslverr} !== 2'b00) $display("FAIL to_after got %b exp 00", {pready, pslverr}); else passed++;
    reg_rd_ack = 1'b1; reg_rd_data = 32'hFFFF0000;
    tick();
    reg_rd_ack = 1'b0;
    tick();
    total++; if ({reg_rd_en, pready, prdata} !== 34'd0) $display("FAIL to_late_ack got %b/%b/%h exp 0", reg_rd_en, pready, prdata); else passed++;
`else
    for (int i = 0; i < 10; i++) begin
      total++; if ({reg_rd_en, pready, pslverr} !== 3'b100) $display("FAIL nto_wait%0d got %b exp 100", i, {reg_rd_en, pready, pslverr}); else passed++;
      tick();
    end
    reg_rd_ack = 1'b1; reg_rd_data = 32'hA5A50F0F;
    tick();
    total++; if ({pready, pslverr, prdata} !== {2'b10, 32'hA5A50F0F}) $display("FAIL nto_resp got %b%b/%h exp 10/a5a50f0f", pready, pslverr, prdata); else passed++;
    bus_idle();
    tick();
`endif
  endtask

  task automatic test_wrong_ack();
    bus_setup(1'b1, 32'h60, 32'h00C0FFEE);
    tick();
    penable = 1'b1; reg_rd_ack = 1'b1; reg_rd_data = 32'h77777777;
    tick();
    reg_rd_ack = 1'b0;
    total++; if ({reg_wr_en, pready} !== 2'b10) $display("FAIL wa_ignored got %b exp 10", {reg_wr_en, pready}); else passed++;
    reg_wr_ack = 1'b1;
    tick();
    total++; if ({reg_wr_en, pready, pslverr, prdata} !== {3'b010, 32'd0}) $display("FAIL wa_done got %b%b%b/%h exp 010/0", reg_wr_en, pready, pslverr, prdata); else passed++;
    bus_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    bus_setup(1'b1, 32'h40, 32'h11223344);
    tick();
    total++; if ({reg_wr_en, reg_rd_en} !== 2'b10) $display("FAIL bb_wr_en got %b exp 10", {reg_wr_en, reg_rd_en}); else passed++;
    penable = 1'b1; reg_wr_ack = 1'b1;
    tick();
    total++; if ({pready, reg_wr_en, reg_rd_en} !== 3'b100) $display("FAIL bb_wr_resp got %b exp 100", {pready, reg_wr_en, reg_rd_en}); else passed++;
    reg_wr_ack = 1'b0;
    bus_setup(1'b0, 32'h44, 32'h0);
    tick();
    total++; if ({pready, reg_wr_en, reg_rd_en} !== 3'b000) $display("FAIL bb_idle got %b exp 000", {pready, reg_wr_en, reg_rd_en}); else passed++;
    tick();
    total++; if ({reg_wr_en, reg_rd_en} !== 2'b01) $display("FAIL bb_rd_en got %b exp 01", {reg_wr_en, reg_rd_en}); else passed++;
    total++; if (reg_rd_addr !== 32'h44) $display("FAIL bb_rd_addr got %h exp 44", reg_rd_addr); else passed++;
    penable = 1'b1; reg_rd_ack = 1'b1; reg_rd_data = 32'hCAFE0001;
    tick();
    total++; if ({pready, prdata} !== {1'b1, 32'hCAFE0001}) $display("FAIL bb_rd got %b/%h exp 1/cafe0001", pready, prdata); else passed++;
    bus_idle();
    tick();
  endtask

  // Direction enables must never overlap at any sampled point.
  always @(negedge clk_i) begin
    if (!srst_i) begin
      total++;
      if (reg_wr_en & reg_rd_en) $display("FAIL en_overlap got 11 exp not both");
      else passed++;
    end
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reset_in_wait();
    test_timeout();
    test_wrong_ack();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_regif_slave.md
APB_REGIF_SLAVE -- requirements
Module: apb_regif_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, range 2..255, number of WAIT cycles allowed without acknowledge.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  rising-edge clock; srst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have the APB ports psel, penable, pwrite  in  1 each; paddr  in  ADDR_WIDTH; pwdata  in  DATA_WIDTH; pstrb  in  STRB_WIDTH; pready, pslverr  out  1 each; prdata  out  DATA_WIDTH.
REQ-007 SHALL have the register-side write ports reg_wr_addr  out  ADDR_WIDTH; reg_wr_data  out  DATA_WIDTH; reg_wr_strb  out  STRB_WIDTH; reg_wr_en  out  1 write request; reg_wr_ack  in  1 write done.
REQ-008 SHALL have the register-side read ports reg_rd_addr  out  ADDR_WIDTH; reg_rd_en  out  1 read request; reg_rd_data  in  DATA_WIDTH; reg_rd_ack  in  1 read data valid.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-010 In IDLE, psel=1 with penable=0 (setup phase) SHALL capture paddr, pwdata, pstrb and pwrite, then go to WAIT on the next edge.
REQ-011 In WAIT, the block SHALL drive registered reg_wr_en=1 when the captured pwrite=1, else reg_rd_en=1, with captured addr/data/strb stable, and SHALL never assert both.
REQ-012 The matching ack sampled high in WAIT SHALL drop the enable on the next edge and move to RESP; for reads, reg_rd_data SHALL be registered into prdata on that edge.
REQ-013 RESP SHALL last exactly one cycle with pready=1, then return to IDLE; pready SHALL be 0 in IDLE and WAIT.
REQ-014 Minimum latency: setup at cycle 0; enable high at cycle 1; ack at cycle 1; pready high at cycle 2.
REQ-015 An ack of the non-matching type, or any ack outside WAIT, SHALL be ignored.
REQ-016 If psel falls while in WAIT, the register access SHALL still complete; RESP SHALL occur but its response is discarded by the master.
REQ-017 prdata SHALL hold its last captured value; it is 0 after a write or an error response.
REQ-018 pslverr SHALL be 0 except as given by REQ-022.

Reset
REQ-019 srst_i high at a clock edge SHALL force IDLE and set pready, pslverr, reg_wr_en and reg_rd_en to 0, prdata to 0, all reg_* address/data/strb to 0, and the timeout counter to 0.
REQ-020 Reset asserted in WAIT or RESP SHALL abandon the transfer; the enable SHALL be low from the first post-reset cycle, and a late ack SHALL be ignored.

Configuration
REQ-021 Macro APB_REGIF_TIMEOUT_EN SHALL compile in a WAIT-cycle counter, cleared on entry to WAIT and incremented each WAIT cycle without ack.
REQ-022 With APB_REGIF_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without ack SHALL drop the enable, enter RESP with pslverr=1 for that cycle and set prdata=0; an ack in the same cycle as expiry SHALL take priority and give pslverr=0.
REQ-023 With APB_REGIF_TIMEOUT_EN undefined, WAIT SHALL persist until ack, no counter SHALL exist, and pslverr SHALL be tied to 0.

Verification
REQ-024 Write to paddr=0x10 with pwdata=0xDEADBEEF and pstrb=0xF, ack in the same cycle as reg_wr_en -> reg_wr_en high for exactly 1 cycle with matching addr/data/strb, then pready=1 and pslverr=0 one cycle later.
REQ-025 Read from paddr=0x24, reg_rd_ack 3 cycles after reg_rd_en rises with reg_rd_data=0x12345678 -> prdata=0x12345678 with pready=1 for exactly 1 cycle.
REQ-026 With the macro defined and TIMEOUT_CYCLES=4, a read with no ack -> reg_rd_en high for 4 cycles, then pready=1, pslverr=1 and prdata=0; an ack 2 cycles later is ignored.
REQ-027 Assert srst_i for 1 cycle during WAIT of a write -> all outputs 0 next cycle, and a following read at paddr=0x0 completes normally.
REQ-028 Back-to-back write then read with psel held between transfers -> the second setup is accepted only from IDLE, and reg_wr_en and reg_rd_en are never high together.
